// File: rtl/mem_copy_ctrl_pkg.sv
// Shared definitions for the mem_copy_ctrl block: FSM state encoding,
// word stride and the byte-alignment check used on command addresses.
package mem_copy_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      FIN   = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam int unsigned DEF_STRIDE = 4;
   localparam logic [1:0]  ALIGN_MASK = 2'b11;

   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_copy_ctrl_if.sv
// Command and mem-side signals of the copy engine; master is the engine,
// slave is the command issuer plus the memory it drives.
interface mem_copy_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 16
);
   logic              start;
   logic [ADDR_W-1:0] srcAddr;
   logic [ADDR_W-1:0] dstAddr;
   logic [CNT_W-1:0]  count;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] memIn;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] memOut;

   modport master (
      input  start, srcAddr, dstAddr, count, memOut,
      output busy, done, error, address, memIn, read, write
   );

   modport slave (
      output start, srcAddr, dstAddr, count, memOut,
      input  busy, done, error, address, memIn, read, write
   );
endinterface

// File: rtl/mem_copy_ctrl_addr_gen.sv
// Source/destination address and remaining-word counter bank for the copy
// engine: loaded on command accept, stepped once per written word.
module mem_addr_gen #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned STRIDE = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [ADDR_W-1:0] i_src,
   input  logic [ADDR_W-1:0] i_dst,
   input  logic [CNT_W-1:0]  i_count,
   output logic [ADDR_W-1:0] o_src_nxt,
   output logic [ADDR_W-1:0] o_dst,
   output logic              o_last
);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [CNT_W-1:0]  r_rem;
   logic [ADDR_W-1:0] w_src_nxt;
   logic [ADDR_W-1:0] w_dst_nxt;

   // Increments wrap modulo 2^ADDR_W by construction.
   assign w_src_nxt = r_src + STEP;
   assign w_dst_nxt = r_dst + STEP;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_src <= '0;
         r_dst <= '0;
         r_rem <= '0;
      end else if (i_load) begin
         r_src <= i_src;
         r_dst <= i_dst;
         r_rem <= i_count;
      end else if (i_step) begin
         r_src <= w_src_nxt;
         r_dst <= w_dst_nxt;
         r_rem <= r_rem - CNT_W'(1);
      end
   end

   assign o_src_nxt = w_src_nxt;
   assign o_dst     = r_dst;
   assign o_last    = (r_rem == CNT_W'(1));

endmodule

// File: rtl/mem_copy_ctrl.sv
// Block-copy engine driving one mem instance: alternates a one-cycle READ
// and a one-cycle WRITE per word, with done/error pulses on completion.
module mem_copy_ctrl
   import mem_copy_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned STRIDE = DEF_STRIDE
) (
   input  logic             clk,
   input  logic             reset,
   mem_copy_ctrl_if.master  bus
);
   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic              r_read;
   logic              r_write;
   logic [ADDR_W-1:0] r_address;
   logic [DATA_W-1:0] r_memIn;

   logic              w_aligned;
   logic              w_zero;
   logic              w_load;
   logic              w_step;
   logic [ADDR_W-1:0] w_src_nxt;
   logic [ADDR_W-1:0] w_dst;
   logic              w_last;

   assign w_aligned = is_aligned(bus.srcAddr[1:0]) && is_aligned(bus.dstAddr[1:0]);
   assign w_zero    = (bus.count == '0);
   assign w_load    = (r_state == IDLE) && bus.start && w_aligned && !w_zero;
   assign w_step    = (r_state == WRITE);

   mem_addr_gen #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .STRIDE (STRIDE)
   ) u_addr_gen (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_src     (bus.srcAddr),
      .i_dst     (bus.dstAddr),
      .i_count   (bus.count),
      .o_src_nxt (w_src_nxt),
      .o_dst     (w_dst),
      .o_last    (w_last)
   );

   // Outputs are registered one state ahead: each transition sets the pins
   // the destination state must present in its own cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         r_address <= '0;
         r_memIn   <= '0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (!w_aligned) begin
                     r_state <= ERR;
                     r_error <= 1'b1;
                  end else if (w_zero) begin
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= READ;
                     r_busy    <= 1'b1;
                     r_read    <= 1'b1;
                     r_address <= bus.srcAddr;
                  end
               end
            end
            READ: begin
               r_state   <= WRITE;
               r_memIn   <= bus.memOut;
               r_read    <= 1'b0;
               r_write   <= 1'b1;
               r_address <= w_dst;
            end
            WRITE: begin
               r_write <= 1'b0;
               if (w_last) begin
                  r_state <= FIN;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state   <= READ;
                  r_read    <= 1'b1;
                  r_address <= w_src_nxt;
               end
            end
            FIN:     r_state <= IDLE;
            ERR:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.error   = r_error;
   assign bus.read    = r_read;
   assign bus.write   = r_write;
   assign bus.address = r_address;
   assign bus.memIn   = r_memIn;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Self-checking bench for mem_copy_ctrl: directed plus random copies checked
// against a word-by-word reference copy over a sparse memory image.
module tb_mem_copy_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_copy_ctrl_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) bus ();

   mem_copy_ctrl #(
      .DATA_W (32),
      .ADDR_W (32),
      .CNT_W  (16),
      .STRIDE (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      mem[a]     = d;
      ref_mem[a] = d;
   endtask

   // The memory lives in this process: writes commit while write=1 is stable
   // before the edge, and memOut follows address combinationally.
   task automatic tick();
      @(negedge clk);
      if (bus.write) mem[bus.address] = bus.memIn;
      bus.memOut = bus.read ? mem_rd(bus.address) : 32'h0;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},  {63'd0, bus.busy},  64'd0);
      check({tag, "_done"},  {63'd0, bus.done},  64'd0);
      check({tag, "_error"}, {63'd0, bus.error}, 64'd0);
      check({tag, "_read"},  {63'd0, bus.read},  64'd0);
      check({tag, "_write"}, {63'd0, bus.write}, 64'd0);
      check({tag, "_addr"},  {32'd0, bus.address}, 64'd0);
      check({tag, "_memIn"}, {32'd0, bus.memIn},   64'd0);
   endtask

   task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cnt,
                          input bit spam, input int rst_at);
      logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
      logic [31:0] got_rd[$], got_wa[$], got_wd[$];
      bit mis;
      int nr, nw, cyc, nbusy, ndone, nerr, both, end_cyc, nreg;
      bit finished;
      logic [31:0] a;

      // Reference: ascending word copy, each word read from the image as it
      // stands after all earlier writes of this command.
      mis = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
      nr  = mis ? 0 : int'(cnt);
      nw  = nr;
      if (rst_at > 0) begin
         if ((rst_at + 1) / 2 < nr) nr = (rst_at + 1) / 2;
         if (rst_at / 2 < nw) nw = rst_at / 2;
      end
      for (int i = 0; i < nr; i++) exp_rd.push_back(src + 32'(4 * i));
      for (int i = 0; i < nw; i++) begin
         logic [31:0] d;
         d = ref_rd(src + 32'(4 * i));
         ref_mem[dst + 32'(4 * i)] = d;
         exp_wa.push_back(dst + 32'(4 * i));
         exp_wd.push_back(d);
      end

      bus.srcAddr = src;
      bus.dstAddr = dst;
      bus.count   = cnt;
      bus.start   = 1'b1;
      cyc = 0; nbusy = 0; ndone = 0; nerr = 0; both = 0; end_cyc = 0;
      finished = 1'b0;
      while (!finished && cyc < 2 * int'(cnt) + 10) begin
         tick();
         cyc++;
         if (!spam) bus.start = 1'b0;
         if (bus.read) got_rd.push_back(bus.address);
         if (bus.write) begin
            got_wa.push_back(bus.address);
            got_wd.push_back(bus.memIn);
         end
         if (bus.read && bus.write) both++;
         if (bus.busy) nbusy++;
         if (bus.done) ndone++;
         if (bus.error) nerr++;
         if (rst_at == cyc) begin
            reset = 1'b1;
            tick();
            check_idle_zero("rst_mid");
            reset = 1'b0;
            finished = 1'b1;
         end else if (bus.done || bus.error) begin
            end_cyc  = cyc;
            finished = 1'b1;
         end
      end
      bus.start = 1'b0;
      if (!finished) check("timeout", 64'd1, 64'd0);

      if (rst_at == 0) begin
         check("done_cnt", 64'(ndone), (mis ? 64'd0 : 64'd1));
         check("err_cnt",  64'(nerr),  (mis ? 64'd1 : 64'd0));
         check("end_cyc",  64'(end_cyc), (mis || cnt == 0) ? 64'd1 : 64'(2 * int'(cnt) + 1));
         check("busy_cyc", 64'(nbusy), mis ? 64'd0 : 64'(2 * int'(cnt)));
         tick();
         check("pulse_done", {63'd0, bus.done},  64'd0);
         check("pulse_err",  {63'd0, bus.error}, 64'd0);
         check("idle_busy",  {63'd0, bus.busy},  64'd0);
      end
      check("rw_both", 64'(both), 64'd0);
      check("rd_n", 64'(got_rd.size()), 64'(exp_rd.size()));
      for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
         check("rd_addr", {32'd0, got_rd[i]}, {32'd0, exp_rd[i]});
      check("wr_n", 64'(got_wa.size()), 64'(exp_wa.size()));
      for (int i = 0; i < got_wa.size() && i < exp_wa.size(); i++) begin
         check("wr_addr", {32'd0, got_wa[i]}, {32'd0, exp_wa[i]});
         check("wr_data", {32'd0, got_wd[i]}, {32'd0, exp_wd[i]});
      end
      nreg = (cnt == 0) ? 1 : ((cnt > 16) ? 16 : int'(cnt));
      for (int i = 0; i < nreg; i++) begin
         a = {dst[31:2], 2'b00} + 32'(4 * i);
         check("dst_word", {32'd0, mem_rd(a)}, {32'd0, ref_rd(a)});
      end
   endtask

   initial begin
      logic [31:0] s, d;
      logic [15:0] c;
      bus.start = 1'b0; bus.srcAddr = '0; bus.dstAddr = '0; bus.count = '0;
      bus.memOut = '0;
      reset = 1'b1;
      repeat (3) tick();
      check_idle_zero("reset");
      reset = 1'b0;
      tick();

      preload(32'd16, 32'h1234_5678);
      preload(32'd20, 32'h89ab_cdef);
      do_copy(32'd16, 32'd64, 16'd2, 1'b0, 0);
      check("plan_w64", {32'd0, mem_rd(32'd64)}, 64'h1234_5678);
      check("plan_w68", {32'd0, mem_rd(32'd68)}, 64'h89ab_cdef);

      do_copy(32'd18, 32'd64, 16'd3, 1'b0, 0);
      check("mis_w64", {32'd0, mem_rd(32'd64)}, 64'h1234_5678);

      do_copy(32'd16, 32'd32, 16'd0, 1'b0, 0);
      do_copy(32'd128, 32'd256, 16'd3, 1'b1, 0);

      do_copy(32'd512, 32'd768, 16'd4, 1'b0, 4);
      tick();
      do_copy(32'd512, 32'd768, 16'd4, 1'b0, 0);

      do_copy(32'hFFFF_FFFC, 32'h100, 16'd2, 1'b0, 0);

      do_copy(32'd16, 32'd24, 16'd4, 1'b0, 0);

      for (int n = 0; n < 25; n++) begin
         s = 32'($urandom_range(0, 255)) << 2;
         d = 32'($urandom_range(0, 255)) << 2;
         if ($urandom_range(0, 7) == 0) s = s | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) d = d | 32'($urandom_range(1, 3));
         c = 16'($urandom_range(0, 9));
         do_copy(s, d, c, 1'($urandom_range(0, 1)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
